// File: rtl/vcache_stat_trigger.sv
// Print-stat request queue serialized into one-hot per-vcache strobes,
// plus the free-running global cycle counter shared by all profilers.
module vcache_stat_trigger #(
  parameter int data_width_p = 32,
  parameter int num_vcache_p = 8,
  parameter int fifo_els_p   = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    req_v_i,
  input  logic [data_width_p-1:0] req_tag_i,
  output logic                    req_ready_o,
  output logic [num_vcache_p-1:0] print_stat_v_o,
  output logic [data_width_p-1:0] print_stat_tag_o,
  output logic [31:0]             global_ctr_o,
  output logic                    busy_o
);

  localparam int lg_vcache_lp =
    (num_vcache_p > 1) ? $clog2(num_vcache_p) : 1;
  localparam int lg_fifo_lp = $clog2(fifo_els_p);
  localparam int cnt_w_lp   = $clog2(fifo_els_p + 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ISSUE = 1'b1;

  logic [31:0] ctr_r;

  logic [data_width_p-1:0] mem_r [fifo_els_p];
  logic [lg_fifo_lp-1:0]   wr_ptr_r;
  logic [lg_fifo_lp-1:0]   rd_ptr_r;
  logic [cnt_w_lp-1:0]     count_r;

  logic [0:0]              state_r;
  logic [lg_vcache_lp-1:0] idx_r;
  logic [data_width_p-1:0] tag_r;

  logic full, empty, enq, deq;
  logic issue, last;

  assign full  = (count_r == cnt_w_lp'(fifo_els_p));
  assign empty = (count_r == '0);
  assign issue = (state_r == S_ISSUE);
  assign last  = (idx_r == lg_vcache_lp'(num_vcache_p - 1));

  // No full-bypass: ready depends only on registered occupancy.
  assign enq = req_v_i & ~full;
  assign deq = ~empty & (~issue | last);

  assign req_ready_o = ~full;
  assign busy_o      = issue | ~empty;
  assign global_ctr_o = ctr_r;

  always_ff @(posedge clk_i) begin
    if (reset_i) ctr_r <= '0;
    else         ctr_r <= ctr_r + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem_r[wr_ptr_r] <= req_tag_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (enq) begin
        if (wr_ptr_r == lg_fifo_lp'(fifo_els_p - 1))
          wr_ptr_r <= '0;
        else
          wr_ptr_r <= wr_ptr_r + lg_fifo_lp'(1);
      end
      if (deq) begin
        if (rd_ptr_r == lg_fifo_lp'(fifo_els_p - 1))
          rd_ptr_r <= '0;
        else
          rd_ptr_r <= rd_ptr_r + lg_fifo_lp'(1);
      end
      if (enq & ~deq)
        count_r <= count_r + cnt_w_lp'(1);
      else if (~enq & deq)
        count_r <= count_r - cnt_w_lp'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= S_IDLE;
      idx_r   <= '0;
      tag_r   <= '0;
    end else begin
      unique case (1'b1)
        (state_r == S_IDLE): begin
          if (~empty) begin
            tag_r   <= mem_r[rd_ptr_r];
            idx_r   <= '0;
            state_r <= S_ISSUE;
          end
        end
        (state_r == S_ISSUE): begin
          if (last) begin
            idx_r <= '0;
            if (~empty) tag_r   <= mem_r[rd_ptr_r];
            else        state_r <= S_IDLE;
          end else begin
            idx_r <= idx_r + lg_vcache_lp'(1);
          end
        end
        default: state_r <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    print_stat_v_o = '0;
    for (int i = 0; i < num_vcache_p; i++)
      print_stat_v_o[i] = issue & (idx_r == lg_vcache_lp'(i));
  end

  assign print_stat_tag_o = issue ? tag_r : '0;

endmodule

// File: tb/tb_vcache_stat_trigger.sv
// Bench for vcache_stat_trigger: schedule-level model of broadcasts
// checked every cycle, plus hand-computed literal expectations.
module tb_vcache_stat_trigger;
  localparam int N  = 8;
  localparam int FE = 4;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_v = 1'b0;
  logic [DW-1:0] req_tag = '0;
  logic ready;
  logic [N-1:0] v;
  logic [DW-1:0] tag;
  logic [31:0] ctr;
  logic busy;

  logic r1_v = 1'b0;
  logic [DW-1:0] r1_tag = '0;
  logic ready1;
  logic [0:0] v1;
  logic [DW-1:0] tag1;
  logic [31:0] ctr1;
  logic busy1;

  always #5 clk = ~clk;

  vcache_stat_trigger #(.data_width_p(DW), .num_vcache_p(N),
                        .fifo_els_p(FE)) dut (
    .clk_i(clk), .reset_i(rst), .req_v_i(req_v), .req_tag_i(req_tag),
    .req_ready_o(ready), .print_stat_v_o(v), .print_stat_tag_o(tag),
    .global_ctr_o(ctr), .busy_o(busy));

  vcache_stat_trigger #(.data_width_p(DW), .num_vcache_p(1),
                        .fifo_els_p(FE)) dut1 (
    .clk_i(clk), .reset_i(rst), .req_v_i(r1_v), .req_tag_i(r1_tag),
    .req_ready_o(ready1), .print_stat_v_o(v1), .print_stat_tag_o(tag1),
    .global_ctr_o(ctr1), .busy_o(busy1));

  // Model: each accepted tag owns a window of N strobe cycles starting
  // at max(accept+2, previous window end+1).
  int cyc = 0;
  int n = 0;
  int last_end = -100;
  int acc_a [64];
  int st_a [64];
  logic [DW-1:0] tag_a [64];
  logic [31:0] mctr = '0;
  logic poke = 1'b0;
  localparam logic [31:0] POKE_VAL = 32'hFFFF_FFFD;

  function automatic int m_occ(input int c);
    int k = 0;
    for (int i = 0; i < n; i++)
      if (acc_a[i] < c && st_a[i] > c) k++;
    return k;
  endfunction

  function automatic logic [N-1:0] m_v(input int c);
    logic [N-1:0] r = '0;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < N; j++)
        if (c == st_a[i] + j) r[j] = 1'b1;
    return r;
  endfunction

  function automatic logic [DW-1:0] m_tag(input int c);
    logic [DW-1:0] r = '0;
    for (int i = 0; i < n; i++)
      if (c >= st_a[i] && c < st_a[i] + N) r = tag_a[i];
    return r;
  endfunction

  function automatic int m_start(input int c);
    return (c + 2 > last_end + 1) ? c + 2 : last_end + 1;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (poke)     mctr <= POKE_VAL + 32'd1;
    else if (rst) mctr <= '0;
    else          mctr <= mctr + 32'd1;
    if (rst) begin
      n <= 0;
      last_end <= -100;
    end else if (req_v && m_occ(cyc) < FE && n < 64) begin
      acc_a[n] <= cyc;
      tag_a[n] <= req_tag;
      st_a[n] <= m_start(cyc);
      last_end <= m_start(cyc) + N - 1;
      n <= n + 1;
    end
  end

  int errors = 0;
  int checks = 0;
  logic model_on = 1'b0;
  logic rec = 1'b0;
  logic [N-1:0] rec_v [$];
  logic [DW-1:0] rec_t [$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (model_on) begin
      chk("ready", 32'(ready), 32'(m_occ(cyc) < FE));
      chk("strobe", 32'(v), 32'(m_v(cyc)));
      chk("tag", tag, m_tag(cyc));
      chk("busy", 32'(busy), 32'(m_occ(cyc) > 0 || m_v(cyc) != '0));
      chk("ctr", ctr, mctr);
    end
    if (rec) begin
      rec_v.push_back(v);
      rec_t.push_back(tag);
    end
  endtask

  task automatic send(input logic [DW-1:0] t, output int at);
    int n0;
    int k = 0;
    req_v = 1'b1;
    req_tag = t;
    at = -1;
    do begin
      n0 = n;
      tick();
      k++;
    end while (n == n0 && k < 60);
    if (n == n0) chk("accept_timeout", 32'(k), 32'(0));
    else at = cyc - 1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) tick();
  endtask

  int ta, tb0, tx, t2;
  int first;

  initial begin
    repeat (2) @(negedge clk);
    model_on = 1'b1;
    rst = 1'b0;

    chk("rst_ctr", ctr, 32'd0);
    chk("rst_v", 32'(v), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_tag", tag, 32'd0);
    repeat (19) tick();
    chk("idle_ctr19", ctr, 32'd19);
    chk("idle_ctr19_n1", ctr1, 32'd19);
    chk("idle_busy", 32'(busy), 32'd0);

    send(32'hA5, ta);
    req_v = 1'b0;
    wait_to(ta + 2);
    chk("single_first_v", 32'(v), 32'h01);
    chk("single_first_tag", tag, 32'hA5);
    wait_to(ta + 3);
    chk("single_second_v", 32'(v), 32'h02);
    wait_to(ta + 9);
    chk("single_last_v", 32'(v), 32'h80);
    chk("single_last_tag", tag, 32'hA5);
    wait_to(ta + 10);
    chk("single_end_v", 32'(v), 32'h00);
    chk("single_end_busy", 32'(busy), 32'd0);

    repeat (3) tick();
    rec = 1'b1;
    send(32'd1, tb0);
    for (int k = 2; k <= 6; k++) begin
      send(32'(k), tx);
      if (k == 5) chk("burst_full_ready", 32'(ready), 32'd0);
    end
    req_v = 1'b0;
    chk("burst_6th_accept", 32'(tx - tb0), 32'd10);
    wait_to(tb0 + 53);
    rec = 1'b0;
    first = -1;
    foreach (rec_v[i]) if (first < 0 && rec_v[i] != '0) first = i;
    chk("burst_has_strobe", 32'(first >= 0), 32'd1);
    if (first >= 0 && first + 48 < rec_v.size()) begin
      for (int j = 0; j < 48; j++) begin
        chk("burst_v", 32'(rec_v[first + j]), 32'(1) << (j % 8));
        chk("burst_tag", rec_t[first + j], 32'(1 + j / 8));
      end
      chk("burst_after_v", 32'(rec_v[first + 48]), 32'd0);
    end

    send(32'h11, tx);
    send(32'h22, t2);
    send(32'h33, t2);
    req_v = 1'b0;
    wait_to(tx + 5);
    chk("mid_v_idx3", 32'(v), 32'h08);
    chk("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_v", 32'(v), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_ready", 32'(ready), 32'd1);
    chk("rst_mid_ctr", ctr, 32'd0);
    send(32'h44, t2);
    req_v = 1'b0;
    wait_to(t2 + 2);
    chk("post_rst_v", 32'(v), 32'h01);
    chk("post_rst_tag", tag, 32'h44);
    wait_to(t2 + 12);
    chk("post_rst_idle_v", 32'(v), 32'd0);
    chk("post_rst_idle_busy", 32'(busy), 32'd0);

    force dut.ctr_r = POKE_VAL;
    poke = 1'b1;
    #1;
    release dut.ctr_r;
    tick();
    poke = 1'b0;
    chk("wrap_fffe", ctr, 32'hFFFF_FFFE);
    tick();
    chk("wrap_ffff", ctr, 32'hFFFF_FFFF);
    tick();
    chk("wrap_0", ctr, 32'h0000_0000);
    tick();
    chk("wrap_1", ctr, 32'h0000_0001);

    r1_v = 1'b1;
    r1_tag = 32'd7;
    tick();
    r1_tag = 32'd9;
    tick();
    r1_v = 1'b0;
    chk("n1_first_v", 32'(v1), 32'd1);
    chk("n1_first_tag", tag1, 32'd7);
    tick();
    chk("n1_second_v", 32'(v1), 32'd1);
    chk("n1_second_tag", tag1, 32'd9);
    tick();
    chk("n1_end_v", 32'(v1), 32'd0);
    chk("n1_end_tag", tag1, 32'd0);
    chk("n1_end_busy", 32'(busy1), 32'd0);
    chk("n1_ready", 32'(ready1), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vcache_stat_trigger.md
Name: vcache_stat_trigger

Overview:
- Upstream feeder for the per-vcache profilers: accepts "print stats" requests, each with a tag, from the host/tile print-stat path. Requests are queued.
- Each request is serialized into a one-cycle print strobe per vcache, one vcache per cycle, so profiler CSV appends never collide.
- Also generates the shared free-running global cycle counter consumed by every profiler.

Parameters:
- data_width_p, 32, width of the print-stat tag (matches vcache data width)
- num_vcache_p, 8, number of downstream vcache profilers; must be >= 1
- fifo_els_p, 4, depth of the request tag queue; must be >= 2
- lg_vcache_lp, `BSG_SAFE_CLOG2(num_vcache_p), derived width of the vcache index

Ports:
- clk_i  input  1  clock
- reset_i  input  1  synchronous active-high reset
- req_v_i  input  1  print-stat request valid
- req_tag_i  input  data_width_p  tag attached to the request
- req_ready_o  output  1  request queue can accept; transfer occurs when req_v_i & req_ready_o
- print_stat_v_o  output  num_vcache_p  one-hot print strobe, bit i drives vcache i's print_stat_v_i
- print_stat_tag_o  output  data_width_p  tag for the strobe currently asserted, shared by all vcaches
- global_ctr_o  output  32  free-running cycle counter, drives every profiler's global_ctr_i
- busy_o  output  1  high while a broadcast is in progress or the queue is non-empty

Behaviour:
- Clock and reset: one clock, clk_i. reset_i is synchronous and active-high.
- Reset values: print_stat_v_o=0, print_stat_tag_o=0, global_ctr_o=0, busy_o=0, req_ready_o=1 (the cycle after reset deasserts). Queue is empty, FSM is in IDLE, vcache index is 0.
- global_ctr_o: increments by 1 every non-reset cycle. Wraps from 32'hFFFF_FFFF to 0. Unaffected by request traffic.
- Queue:
  - FIFO of fifo_els_p tags with registered occupancy.
  - req_ready_o = ~full, based on registered occupancy. While full, ready stays 0 even in a cycle where a dequeue occurs; there is no full-bypass.
  - There is no empty-bypass either: a tag enqueued at cycle t is visible to the FSM at t+1.
  - Simultaneous enqueue and dequeue when not full: occupancy unchanged, FIFO order preserved.
- FSM states: IDLE, ISSUE.
  - IDLE: all strobes 0. If the queue is non-empty: latch the head tag into tag_r, dequeue, set idx_r=0, go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: print_stat_v_o = one-hot(idx_r) and print_stat_tag_o = tag_r.
    - If idx_r == num_vcache_p-1 and the queue is non-empty: latch the next head, dequeue, set idx_r=0, stay in ISSUE (back-to-back requests, no gap).
    - If idx_r == num_vcache_p-1 and the queue is empty: go to IDLE, idx_r=0.
    - Otherwise: idx_r++.
- print_stat_tag_o is 0 whenever print_stat_v_o is 0.
- Latency: a request accepted at cycle t strobes vcache 0 at t+2 and vcache num_vcache_p-1 at t+1+num_vcache_p.
- Sustained throughput is one request per num_vcache_p cycles.
- busy_o = (state==ISSUE) | queue non-empty.
- Exactly one print_stat_v_o bit is high in ISSUE, never more. No strobe is ever dropped or repeated.
- Reset mid-broadcast: the next cycle the FSM is in IDLE, the queue is flushed (pending tags discarded), strobes are 0, and global_ctr_o is 0.
- num_vcache_p=1: each request produces exactly one strobe cycle on bit 0.
- No backpressure from the profilers; the strobe is a single-cycle pulse sampled by each profiler on the following negedge.

Test Plan:
- Post-reset idle, 20 cycles, no requests -> print_stat_v_o=0, busy_o=0, req_ready_o=1, global_ctr_o counts 0..19.
- Single request, tag=32'hA5, accepted at cycle 10 (num_vcache_p=8):
  - print_stat_v_o = 8'h01 at cycle 12, 8'h02 at 13, ..., 8'h80 at 19, each with tag 32'hA5.
  - Zero at cycle 20; busy_o falls at cycle 20.
- Burst of 6 requests on consecutive cycles, tags 1..6, fifo_els_p=4:
  - req_ready_o drops once 4 tags are held; the 6th request waits and is accepted after the first dequeue.
  - 48 contiguous strobe cycles, tags in order 1..6, no gaps between broadcasts.
- Reset asserted during ISSUE at idx_r=3 with 2 tags queued -> next cycle strobes=0, busy_o=0, req_ready_o=1. A later new request broadcasts from vcache 0 with the new tag only.
- Force global_ctr_o near wrap (run from 32'hFFFF_FFFD via a long run or a bench backdoor) -> sequence FFFF_FFFE, FFFF_FFFF, 0, 1.
- num_vcache_p=1, two back-to-back requests, tags 7 and 9 -> print_stat_v_o=1 on consecutive cycles with tags 7 then 9.
